// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak nonce scheduler.
//   NONCE_W / HASH_W : nonce and hash widths
//   state_e          : scheduler FSM encoding
//   tag_t            : in-flight tag {epoch, nonce}
//   hit()            : hash <= target, 256-bit unsigned
package keccak_pkg;
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  typedef struct packed {
    logic               epoch;
    logic [NONCE_W-1:0] nonce;
  } tag_t;

  function automatic logic hit(input logic [HASH_W-1:0] hash,
                               input logic [HASH_W-1:0] target);
    return hash <= target;
  endfunction
endpackage

// File: rtl/keccak_tag_fifo.sv
// In-order tag FIFO for in-flight hasher requests.
//   clk, rst_n         : clock, async active-low reset
//   push_i / wdata_i   : enqueue a tag (ignored when full)
//   pop_i  / rdata_o   : dequeue; rdata_o shows the head (show-ahead)
//   full_o / empty_o   : fill flags
//   level_o            : current occupancy
module keccak_tag_fifo
  import keccak_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  tag_t                   wdata_i,
  input  logic                   pop_i,
  output tag_t                   rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  tag_t        mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/keccak_nonce_scheduler.sv
// Mining sequencer in front of one keccak_hasher.
// Splices an incrementing nonce into the latched header, issues one hasher
// read per THROUGHPUT clocks, tracks in-flight nonces in issue order and
// reports hashes that are <= target.
//   clk, rst_n                      : clock, async active-low reset
//   work_data/work_target/work_load : host work interface (load strobe restarts)
//   hash_in/hash_read               : registered request to the hasher
//   hash_out/hash_write             : hasher result, in issue order
//   result_nonce/result_valid/ack   : hit report, held until acked
//   result_drop                     : pulse, a hit was lost while one was pending
//   busy, nonce_wrapped             : status
module keccak_nonce_scheduler
  import keccak_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int NONCE_LSB  = 608,
  parameter int THROUGHPUT = 1,
  parameter int INFLIGHT   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   work_data,
  input  logic [HASH_W-1:0]  work_target,
  input  logic               work_load,
  output logic [WIDTH-1:0]   hash_in,
  output logic               hash_read,
  input  logic [HASH_W-1:0]  hash_out,
  input  logic               hash_write,
  output logic [NONCE_W-1:0] result_nonce,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               result_drop,
  output logic               busy,
  output logic               nonce_wrapped
);
  localparam int CNT_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
  localparam int LVL_W = $clog2(INFLIGHT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THROUGHPUT - 1);
  localparam logic [CNT_W-1:0] CNT_NXT = (THROUGHPUT > 1) ? CNT_W'(1) : '0;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hdr_q, hdr_d;
  logic [HASH_W-1:0]    target_q, target_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic                 epoch_q, epoch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hash_in_q, hash_in_d;
  logic                 hash_read_q, hash_read_d;
  logic                 wrapped_q, wrapped_d;
  logic                 res_valid_q, res_valid_d;
  logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
  logic                 drop_q, drop_d;

  // Issue context: a load takes effect in the same cycle so the first read
  // leaves on the cycle right after work_load.
  logic                 run_eff, epoch_eff;
  logic [NONCE_W-1:0]   nonce_eff;
  logic [CNT_W-1:0]     cnt_eff;
  logic [WIDTH-1:0]     hdr_eff;

  logic                 push, pop, full, empty, hit_w;
  logic [LVL_W-1:0]     level;
  tag_t                 wtag, rtag;

  keccak_tag_fifo #(.DEPTH(INFLIGHT)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i(wtag),
    .pop_i  (pop),
    .rdata_o(rtag),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign pop   = hash_write && !empty;
  // Pops are judged against the pre-load epoch/target even when work_load coincides.
  assign hit_w = pop && (rtag.epoch == epoch_q) && hit(hash_out, target_q);
  assign wtag  = '{epoch: epoch_eff, nonce: nonce_eff};

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    target_d    = target_q;
    epoch_d     = epoch_q;
    hash_in_d   = hash_in_q;
    hash_read_d = 1'b0;
    wrapped_d   = 1'b0;
    push        = 1'b0;
    run_eff     = (state_q == S_RUN);
    nonce_eff   = nonce_q;
    cnt_eff     = cnt_q;
    epoch_eff   = epoch_q;
    hdr_eff     = hdr_q;

    if (work_load) begin
      hdr_d     = work_data;
      target_d  = work_target;
      epoch_d   = ~epoch_q;
      state_d   = S_RUN;
      run_eff   = 1'b1;
      nonce_eff = work_data[NONCE_LSB +: NONCE_W];
      cnt_eff   = '0;
      epoch_eff = ~epoch_q;
      hdr_eff   = work_data;
    end

    nonce_d = nonce_eff;
    cnt_d   = cnt_eff;

    if (run_eff) begin
      if (cnt_eff == '0) begin
        // Full FIFO stalls with the counter parked at 0.
        if (!full) begin
          push        = 1'b1;
          hash_read_d = 1'b1;
          hash_in_d   = hdr_eff;
          hash_in_d[NONCE_LSB +: NONCE_W] = nonce_eff;
          nonce_d     = nonce_eff + 1'b1;
          cnt_d       = CNT_NXT;
          if (nonce_eff == '1) begin
            wrapped_d = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end else begin
        cnt_d = (cnt_eff == CNT_MAX) ? '0 : cnt_eff + 1'b1;
      end
    end else if (state_q == S_DRAIN && (empty || (level == LVL_W'(1) && pop))) begin
      // Leave DRAIN on the edge that pops the last tag.
      state_d = S_IDLE;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_nonce_d = res_nonce_q;
    drop_d      = 1'b0;
    if (hit_w) begin
      if (!res_valid_q || result_ack) begin
        res_valid_d = 1'b1;
        res_nonce_d = rtag.nonce;
      end else begin
        drop_d = 1'b1;
      end
    end else if (result_ack) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      epoch_q     <= 1'b0;
      cnt_q       <= '0;
      hash_in_q   <= '0;
      hash_read_q <= 1'b0;
      wrapped_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_nonce_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      target_q    <= target_d;
      nonce_q     <= nonce_d;
      epoch_q     <= epoch_d;
      cnt_q       <= cnt_d;
      hash_in_q   <= hash_in_d;
      hash_read_q <= hash_read_d;
      wrapped_q   <= wrapped_d;
      res_valid_q <= res_valid_d;
      res_nonce_q <= res_nonce_d;
      drop_q      <= drop_d;
    end
  end

  assign hash_in       = hash_in_q;
  assign hash_read     = hash_read_q;
  assign nonce_wrapped = wrapped_q;
  assign result_valid  = res_valid_q;
  assign result_nonce  = res_nonce_q;
  assign result_drop   = drop_q;
  assign busy          = (state_q != S_IDLE) || !empty;
endmodule
